cmp_share_arb: RTL
==================

CMP_SHARE_ARB -- requirements
Module: cmp_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the comparator (2..8).
REQ-002 SHALL have parameter W, default 4, operand width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_a  input  NREQ*W  operand A; requester i occupies bits [i*W +: W].
REQ-007 SHALL have port req_b  input  NREQ*W  operand B; same packing as req_a.
REQ-008 SHALL have port req_ready  output  NREQ  one-hot accept strobe; at most one bit set per cycle.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-012 SHALL have ports rsp_equal, rsp_greater, rsp_lesser  output  1 each  A==B, A>B, A<B; exactly one set while rsp_valid.
REQ-013 SHALL have port op_count  output  8  count of completed response handshakes, wraps 255->0.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-015 IDLE: if any req_valid bit is set, SHALL grant the first set bit at or after round-robin pointer ptr (searching upward, wrapping), assert req_ready[grant] combinationally in that cycle, capture operands and id, and go to EXEC.
REQ-016 IDLE with req_valid==0: SHALL stay in IDLE, req_ready==0.
REQ-017 EXEC: SHALL drive captured operands into the comparator and register eq/gt/lt, then go to RESP unconditionally.
REQ-018 RESP: rsp_valid SHALL be 1 and rsp_id/rsp_* SHALL stay stable until rsp_valid && rsp_ready.
REQ-019 On the response handshake: SHALL go to IDLE, set ptr = (grant+1) mod NREQ, and increment op_count.
REQ-020 Latency: accept in cycle T -> rsp_valid first high in cycle T+2; minimum spacing between accepts is 3 cycles.
REQ-021 req_ready SHALL be 0 in EXEC and RESP regardless of req_valid.
REQ-022 Requesters SHALL hold req_valid and operands until req_ready; the block does not sample unaccepted operands.
REQ-023 A requester that drops req_valid before grant SHALL be skipped with no state change.
REQ-024 rsp_ready held high in RESP SHALL complete the handshake in the first RESP cycle.

Reset
REQ-025 While rst is high: state=IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_equal/greater/lesser=0, op_count=0, req_ready=0.
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight operation without emitting a response.

Configuration
REQ-027 Macro CMP_SHARE_SIGNED_EN defined: SHALL add port req_signed  input  NREQ, captured with the operands; a set bit compares operands as two's complement.
REQ-028 Macro CMP_SHARE_SIGNED_EN undefined: req_signed port SHALL be absent and all compares unsigned.

Structure
REQ-029 Shared package cmp_share_pkg SHALL hold the FSM state enum (IDLE, EXEC, RESP) and the op_count width constant.
REQ-030 SHALL instantiate one sub-module mag_cmp4: a combinational W-bit magnitude comparator (eq/gt/lt) with a signed-mode input tied low when CMP_SHARE_SIGNED_EN is undefined.
REQ-031 Round-robin grant logic SHALL stay inline in cmp_share_arb.

Verification
REQ-032 Single request: req_valid=0001, A=9, B=3 -> req_ready=0001 at T, rsp_valid at T+2 with id=0, greater=1.
REQ-033 Contention: req_valid=1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0, one accept every 3 cycles.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP with A=B=7 -> equal=1 and id stay stable, no new req_ready, op_count unchanged until handshake.
REQ-035 Reset in EXEC: rst pulsed one cycle after an accept -> rsp_valid never rises, ptr=0, next grant goes to lowest-indexed valid requester.
REQ-036 Wrap: 256 completed operations -> op_count returns to 0.
REQ-037 Signed mode (CMP_SHARE_SIGNED_EN): A=4'b1111, B=4'b0001, req_signed=1 -> lesser=1; req_signed=0 -> greater=1.

Source files
------------

// File: rtl/cmp_share_pkg.sv
// cmp_share_pkg: shared types and constants for the
// shared magnitude-comparator arbiter (cmp_share_arb).
package cmp_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int OPCNT_W = 8;

endpackage

// File: rtl/mag_cmp4.sv
// mag_cmp4: combinational W-bit magnitude comparator.
// signed_i=1 treats both operands as two's complement.
module mag_cmp4 #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         signed_i,
   output logic         eq_o,
   output logic         gt_o,
   output logic         lt_o
);

   logic [W-1:0] flip;
   logic [W-1:0] ax;
   logic [W-1:0] bx;

   // Inverting the sign bit maps two's complement order
   // onto unsigned order, so one unsigned compare serves both.
   assign flip = {signed_i, {(W-1){1'b0}}};
   assign ax   = a_i ^ flip;
   assign bx   = b_i ^ flip;

   assign eq_o = (a_i == b_i);
   assign gt_o = (ax > bx);
   assign lt_o = (ax < bx);

endmodule

// File: rtl/cmp_share_arb.sv
// cmp_share_arb: NREQ requesters share one comparator via a
// round-robin arbiter. Optional macro: CMP_SHARE_SIGNED_EN.
module cmp_share_arb
   import cmp_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*W-1:0]        req_a,
   input  logic [NREQ*W-1:0]        req_b,
`ifdef CMP_SHARE_SIGNED_EN
   input  logic [NREQ-1:0]          req_signed,
`endif
   output logic [NREQ-1:0]          req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic                     rsp_equal,
   output logic                     rsp_greater,
   output logic                     rsp_lesser,
   output logic [OPCNT_W-1:0]       op_count
);

   localparam int IDW = $clog2(NREQ);

   state_e             state_q;
   state_e             state_d;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     id_q;
   logic [IDW-1:0]     gnt_idx;
   logic [IDW:0]       gsum;
   logic               gnt_found;
   logic               accept;
   logic               hshk;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       sel_a;
   logic [W-1:0]       sel_b;
   logic               c_eq;
   logic               c_gt;
   logic               c_lt;
   logic               eq_q;
   logic               gt_q;
   logic               lt_q;
   logic [OPCNT_W-1:0] cnt_q;

   // Round-robin search: first valid at or after ptr_q, wrapping.
   // Walking downward lets the lowest offset win the last write.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gsum      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         gsum = {1'b0, ptr_q} + (IDW+1)'(k);
         if (gsum >= (IDW+1)'(NREQ)) begin
            gsum = gsum - (IDW+1)'(NREQ);
         end
         if (req_valid[gsum[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = gsum[IDW-1:0];
         end
      end
   end

   assign sel_a  = req_a[gnt_idx*W +: W];
   assign sel_b  = req_b[gnt_idx*W +: W];
   assign accept = (state_q == IDLE) && gnt_found;
   assign hshk   = (state_q == RESP) && rsp_ready;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: one compare cycle, then hold until taken
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (gnt_found) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: accept strobe only in IDLE, response only in RESP
   always_comb begin
      req_ready = '0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gnt_found && !rst) begin
               req_ready = NREQ'(1) << gnt_idx;
            end
         end
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

`ifdef CMP_SHARE_SIGNED_EN
   logic sgn_q;

   // Signed-mode flag travels with the captured operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sgn_q <= 1'b0;
      end else if (accept) begin
         sgn_q <= req_signed[gnt_idx];
      end
   end

   mag_cmp4 #(.W(W)) u_cmp (
      .a_i      (a_q),
      .b_i      (b_q),
      .signed_i (sgn_q),
      .eq_o     (c_eq),
      .gt_o     (c_gt),
      .lt_o     (c_lt)
   );
`else
   mag_cmp4 #(.W(W)) u_cmp (
      .a_i      (a_q),
      .b_i      (b_q),
      .signed_i (1'b0),
      .eq_o     (c_eq),
      .gt_o     (c_gt),
      .lt_o     (c_lt)
   );
`endif

   // Datapath: capture on accept, compare in EXEC, retire on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         id_q  <= '0;
         eq_q  <= 1'b0;
         gt_q  <= 1'b0;
         lt_q  <= 1'b0;
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         if (accept) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            id_q <= gnt_idx;
         end
         if (state_q == EXEC) begin
            eq_q <= c_eq;
            gt_q <= c_gt;
            lt_q <= c_lt;
         end
         if (hshk) begin
            ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign rsp_id      = id_q;
   assign rsp_equal   = eq_q;
   assign rsp_greater = gt_q;
   assign rsp_lesser  = lt_q;
   assign op_count    = cnt_q;

endmodule
